// File: rtl/split_pkg.sv
// split_pkg: shared state encodings and default packet geometry for packet_split
package split_pkg;
  typedef enum logic {I_IDLE, I_WAIT_LOW} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_WAIT_ACK, O_WAIT_LOW} out_state_t;
  localparam int PKT_W = 33;
  localparam int DEST_BIT = 32;
endpackage

// File: rtl/split_out_port.sv
// split_out_port: per-output FIFO, 4-phase sender with launch register and delivered counter (push/push_data/full in, out_req/out_data/out_ack/cnt out)
module split_out_port import split_pkg::*; #(
  parameter int WIDTH = PKT_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  out_state_t state, state_nx;
  logic pop, done;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = state == O_IDLE && count != '0;
  assign done = state == O_WAIT_ACK && out_ack;
  assign out_req = state == O_WAIT_ACK;
  always_comb
    state_nx = pop ? O_WAIT_ACK : done ? O_WAIT_LOW : (state == O_WAIT_LOW && !out_ack) ? O_IDLE : state;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= O_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_data <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        out_data <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (done) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/packet_split.sv
// packet_split: 4-phase input stage steering packets by destination bit into two independent output ports
module packet_split import split_pkg::*; #(
  parameter int WIDTH = PKT_W,
  parameter int DEST_BIT = WIDTH-1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out0_req,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ack,
  output logic             out1_req,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ack,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  in_state_t state, state_nx;
  logic sel, full0, full1, take;
  assign sel = in_data[DEST_BIT];
  assign take = state == I_IDLE && in_req && !(sel ? full1 : full0);
  assign in_ack = state == I_WAIT_LOW;
  always_comb
    state_nx = take ? I_WAIT_LOW : (state == I_WAIT_LOW && !in_req) ? I_IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= I_IDLE;
    else state <= state_nx;
  split_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_port0 (
    .clk(clk), .rst_n(rst_n), .push(take && !sel), .push_data(in_data), .full(full0),
    .out_req(out0_req), .out_data(out0_data), .out_ack(out0_ack), .cnt(cnt0)
  );
  split_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_port1 (
    .clk(clk), .rst_n(rst_n), .push(take && sel), .push_data(in_data), .full(full1),
    .out_req(out1_req), .out_data(out1_data), .out_ack(out1_ack), .cnt(cnt1)
  );
endmodule

// File: tb/tb_packet_split.sv
// tb_packet_split: scoreboard bench for packet_split with randomized packets and ack delays
module tb_packet_split;
  localparam int W = 33;
  logic clk = 0, rst_n = 0, in_req = 0, in_ack;
  logic [W-1:0] in_data = '0, out0_data, out1_data;
  logic out0_req, out1_req, out0_ack = 0, out1_ack = 0;
  logic [7:0] cnt0, cnt1;
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] q0[$], q1[$];
  bit hold[2];
  int ncnt[2];
  int dly_max = 0;
  always #5 clk = ~clk;
  packet_split dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out0_req(out0_req), .out0_data(out0_data), .out0_ack(out0_ack),
    .out1_req(out1_req), .out1_data(out1_data), .out1_ack(out1_ack),
    .cnt0(cnt0), .cnt1(cnt1)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic get_req(input int p);
    return p != 0 ? out1_req : out0_req;
  endfunction
  function automatic logic [W-1:0] get_data(input int p);
    return p != 0 ? out1_data : out0_data;
  endfunction
  function automatic logic [7:0] get_cnt(input int p);
    return p != 0 ? cnt1 : cnt0;
  endfunction
  task automatic set_ack(input int p, input logic v);
    if (p != 0) out1_ack = v;
    else out0_ack = v;
  endtask
  task automatic push_exp(input logic [W-1:0] d);
    if (d[W-1]) q1.push_back(d);
    else q0.push_back(d);
  endtask
  task automatic pop_exp(input int p, output logic [W-1:0] d, output bit ok);
    d = '0;
    ok = p != 0 ? q1.size() > 0 : q0.size() > 0;
    if (ok) d = p != 0 ? q1.pop_front() : q0.pop_front();
  endtask
  task automatic respond(input int p);
    logic [W-1:0] e;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n && get_req(p) && !hold[p]) begin
        pop_exp(p, e, ok);
        if (!ok) chk("out_unexpected", 1, 0);
        else chk(p != 0 ? "out1_data" : "out0_data", get_data(p), e);
        repeat ($urandom_range(dly_max, 0)) @(negedge clk);
        set_ack(p, 1);
        @(negedge clk);
        ncnt[p] = (ncnt[p] + 1) % 256;
        chk("out_req_drop", get_req(p), 0);
        chk(p != 0 ? "cnt1" : "cnt0", get_cnt(p), ncnt[p]);
        repeat ($urandom_range(dly_max, 0)) @(negedge clk);
        set_ack(p, 0);
      end
    end
  endtask
  task automatic wait_ack(input logic v, input int lim, input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (in_ack === v) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(name, in_ack, v);
  endtask
  task automatic send(input logic [W-1:0] d);
    bit ok;
    in_data = d;
    in_req = 1;
    wait_ack(1, 500, "in_ack_rise_timeout", ok);
    if (ok) push_exp(d);
    in_req = 0;
    wait_ack(0, 50, "in_ack_fall_timeout", ok);
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !out0_req && !out1_req && !out0_ack && !out1_ack) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] e;
    bit ok;
    fork
      respond(0);
      respond(1);
    join_none
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ack, out0_req, out1_req, out0_data, out1_data, cnt0, cnt1}, 0);
    rst_n = 1;
    @(negedge clk);
    in_data = 33'h0_0000_0015;
    in_req = 1;
    @(negedge clk);
    chk("in_ack_latency", in_ack, 1);
    chk("out0_req_early", out0_req, 0);
    q0.push_back(in_data);
    in_req = 0;
    @(negedge clk);
    chk("in_ack_fall_latency", in_ack, 0);
    chk("out0_req_latency", out0_req, 1);
    send(33'h1_0000_002A);
    drain();
    chk("single_cnt0", cnt0, 1);
    chk("single_cnt1", cnt1, 1);
    hold[0] = 1;
    repeat (3) send({1'b0, 32'($urandom)});
    in_data = {1'b0, 32'($urandom)};
    in_req = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ack", in_ack, 0);
    end
    chk("hol_out1_idle", out1_req, 0);
    hold[0] = 0;
    wait_ack(1, 100, "stall_accept_timeout", ok);
    if (ok) push_exp(in_data);
    in_req = 0;
    wait_ack(0, 50, "stall_release_timeout", ok);
    send({1'b1, 32'($urandom)});
    drain();
    hold[1] = 1;
    repeat (3) send({1'b1, 32'($urandom)});
    pop_exp(1, e, ok);
    chk("pp_head_data", out1_data, e);
    out1_ack = 1;
    @(negedge clk);
    chk("pp_req_drop", out1_req, 0);
    ncnt[1] = (ncnt[1] + 1) % 256;
    chk("pp_cnt1", cnt1, ncnt[1]);
    out1_ack = 0;
    @(negedge clk);
    in_data = {1'b1, 32'($urandom)};
    in_req = 1;
    @(negedge clk);
    chk("pp_refused_on_pop", in_ack, 0);
    chk("pp_relaunch", out1_req, 1);
    @(negedge clk);
    chk("pp_accepted_next", in_ack, 1);
    push_exp(in_data);
    in_req = 0;
    hold[1] = 0;
    wait_ack(0, 50, "pp_release_timeout", ok);
    drain();
    dly_max = 4;
    repeat (12) send({1'($urandom_range(1, 0)), 32'($urandom)});
    drain();
    dly_max = 0;
    hold[0] = 1;
    repeat (2) send({1'b0, 32'($urandom)});
    in_data = {1'b0, 32'($urandom)};
    in_req = 1;
    wait_ack(1, 100, "rst_setup_timeout", ok);
    #2 rst_n = 0;
    #1 chk("reset_async", {in_ack, out0_req, out1_req, out0_data, out1_data, cnt0, cnt1}, 0);
    in_req = 0;
    q0.delete();
    q1.delete();
    ncnt = '{0, 0};
    hold[0] = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_idle", {in_ack, out0_req, out1_req}, 0);
    end
    repeat (256) send({1'b0, 32'($urandom)});
    drain();
    chk("cnt0_wrap", cnt0, 0);
    chk("cnt1_after_wrap", cnt1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
